// File: rtl/motor_cmd_arbiter.sv
// Motor command arbiter: prioritised command decode, dead time between
// opposing drive patterns, and latched overcurrent / metal-detect shutdown.
module motor_cmd_arbiter #(
  parameter int unsigned DEADTIME_CYC   = 1000,
  parameter int unsigned FAULT_HOLD_CYC = 100000
) (
  input  logic       RAW_clk,
  input  logic       RAW_reset,
  input  logic       ON_CURRENT,
  input  logic       InductiveSNSFlag,
  input  logic       Direction,
  input  logic       Rotate,
  input  logic       Move,
  input  logic [3:0] FreqState,
  output logic       Forward1,
  output logic       Backwards1,
  output logic       Forward2,
  output logic       Backwards2,
  output logic [1:0] speedL,
  output logic [1:0] speedR,
  output logic [2:0] arb_state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRIVE    = 3'd1,
    ST_DEADTIME = 3'd2,
    ST_HALT     = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  // Pattern layout is {F1,B1,F2,B2,speedL,speedR}
  localparam logic [7:0]  PAT_STOP   = 8'b0000_0000;
  localparam logic [7:0]  PAT_FWD    = 8'b1010_1111;
  localparam logic [7:0]  PAT_SPIN_R = 8'b1001_1010;
  localparam logic [7:0]  PAT_SPIN_L = 8'b0110_1010;
  localparam logic [23:0] DEAD_LOAD  = 24'(DEADTIME_CYC);
  localparam logic [23:0] FAULT_LOAD = 24'(FAULT_HOLD_CYC);

  state_t      r_state;
  logic [7:0]  r_pat;
  logic [23:0] r_dead_cnt;
  logic [23:0] r_fault_cnt;

  state_t      w_state_nxt;
  logic [7:0]  w_pat_nxt;
  logic [23:0] w_dead_nxt;
  logic [23:0] w_fault_nxt;
  logic [7:0]  w_cmd_pat;
  logic        w_target;

  assign w_target = (FreqState != 4'd0);

  // Localisation request decode; fault and halt flags are handled by the FSM
  always_comb begin
    w_cmd_pat = PAT_STOP;
    if (Rotate && w_target) begin
      w_cmd_pat = Direction ? PAT_SPIN_R : PAT_SPIN_L;
    end else if (Move && w_target) begin
      w_cmd_pat = PAT_FWD;
    end else begin
      w_cmd_pat = PAT_STOP;
    end
  end

  // Next-state, next-pattern and counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = PAT_STOP;
    w_dead_nxt  = 24'd0;
    w_fault_nxt = 24'd0;
    if (ON_CURRENT) begin
      w_state_nxt = ST_FAULT;
      w_fault_nxt = FAULT_LOAD;
    end else begin
      case (r_state)
        ST_FAULT: begin
          if (r_fault_cnt == 24'd0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_FAULT;
            w_fault_nxt = r_fault_cnt - 24'd1;
          end
        end
        ST_HALT: begin
          if (InductiveSNSFlag) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (InductiveSNSFlag) begin
            w_state_nxt = ST_HALT;
          end else if (w_cmd_pat != PAT_STOP) begin
            w_state_nxt = ST_DRIVE;
            w_pat_nxt   = w_cmd_pat;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DRIVE: begin
          if (InductiveSNSFlag) begin
            w_state_nxt = ST_HALT;
          end else if (w_cmd_pat == PAT_STOP) begin
            w_state_nxt = ST_IDLE;
          end else if (w_cmd_pat == r_pat) begin
            w_state_nxt = ST_DRIVE;
            w_pat_nxt   = r_pat;
          end else begin
            w_state_nxt = ST_DEADTIME;
            w_dead_nxt  = DEAD_LOAD;
          end
        end
        ST_DEADTIME: begin
          // Command changes inside the window are ignored until the last cycle
          if (InductiveSNSFlag) begin
            w_state_nxt = ST_HALT;
          end else if (r_dead_cnt > 24'd1) begin
            w_state_nxt = ST_DEADTIME;
            w_dead_nxt  = r_dead_cnt - 24'd1;
          end else if (w_cmd_pat != PAT_STOP) begin
            w_state_nxt = ST_DRIVE;
            w_pat_nxt   = w_cmd_pat;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, output pattern and counter registers
  always_ff @(posedge RAW_clk or posedge RAW_reset) begin
    if (RAW_reset) begin
      r_state     <= ST_IDLE;
      r_pat       <= PAT_STOP;
      r_dead_cnt  <= 24'd0;
      r_fault_cnt <= 24'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_pat       <= w_pat_nxt;
      r_dead_cnt  <= w_dead_nxt;
      r_fault_cnt <= w_fault_nxt;
    end
  end

  assign Forward1   = r_pat[7];
  assign Backwards1 = r_pat[6];
  assign Forward2   = r_pat[5];
  assign Backwards2 = r_pat[4];
  assign speedL     = r_pat[3:2];
  assign speedR     = r_pat[1:0];
  assign arb_state  = r_state;

endmodule

// File: tb/tb_motor_cmd_arbiter.sv
// Self-checking bench for motor_cmd_arbiter: directed scenarios with literal
// expectations, then randomized stimulus against a behavioural model.
module tb_motor_cmd_arbiter;

  localparam int DT = 4;
  localparam int FH = 8;
  localparam logic [7:0] FWD = 8'b1010_1111;
  localparam logic [7:0] SPR = 8'b1001_1010;
  localparam logic [7:0] SPL = 8'b0110_1010;

  logic       RAW_clk = 1'b0;
  logic       RAW_reset;
  logic       ON_CURRENT;
  logic       InductiveSNSFlag;
  logic       Direction;
  logic       Rotate;
  logic       Move;
  logic [3:0] FreqState;
  logic       Forward1, Backwards1, Forward2, Backwards2;
  logic [1:0] speedL, speedR;
  logic [2:0] arb_state;

  int checks = 0;
  int errors = 0;

  always #5 RAW_clk = ~RAW_clk;

  motor_cmd_arbiter #(.DEADTIME_CYC(DT), .FAULT_HOLD_CYC(FH)) dut (
    .RAW_clk(RAW_clk), .RAW_reset(RAW_reset), .ON_CURRENT(ON_CURRENT),
    .InductiveSNSFlag(InductiveSNSFlag), .Direction(Direction), .Rotate(Rotate),
    .Move(Move), .FreqState(FreqState), .Forward1(Forward1), .Backwards1(Backwards1),
    .Forward2(Forward2), .Backwards2(Backwards2), .speedL(speedL), .speedR(speedR),
    .arb_state(arb_state)
  );

  wire [7:0] dut_vec = {Forward1, Backwards1, Forward2, Backwards2, speedL, speedR};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode codes are the published arb_state values
  int         m_mode = 0;
  logic [7:0] m_vec = 8'd0;
  int         m_dead_left = 0;
  int         m_hold = 0;

  function automatic logic [7:0] wanted();
    if (FreqState == 4'd0) return 8'd0;
    if (Rotate) return Direction ? SPR : SPL;
    if (Move) return FWD;
    return 8'd0;
  endfunction

  always @(posedge RAW_clk or posedge RAW_reset) begin
    if (RAW_reset) begin
      m_mode <= 0; m_vec <= 8'd0; m_dead_left <= 0; m_hold <= 0;
    end else if (ON_CURRENT) begin
      m_mode <= 4; m_vec <= 8'd0; m_hold <= FH;
    end else if (m_mode == 4) begin
      if (m_hold == 0) m_mode <= 0;
      else m_hold <= m_hold - 1;
    end else if (m_mode == 3) begin
      if (!InductiveSNSFlag) m_mode <= 0;
    end else if (InductiveSNSFlag) begin
      m_mode <= 3; m_vec <= 8'd0;
    end else if (m_mode == 0) begin
      if (wanted() != 8'd0) begin m_mode <= 1; m_vec <= wanted(); end
    end else if (m_mode == 1) begin
      if (wanted() == 8'd0) begin
        m_mode <= 0; m_vec <= 8'd0;
      end else if (wanted() != m_vec) begin
        m_mode <= 2; m_vec <= 8'd0; m_dead_left <= DT;
      end
    end else begin
      if (m_dead_left > 1) m_dead_left <= m_dead_left - 1;
      else begin
        m_dead_left <= 0;
        m_mode <= (wanted() != 8'd0) ? 1 : 0;
        m_vec <= wanted();
      end
    end
  end

  // Per-cycle comparison against the model, plus the H-bridge shoot-through rule
  always @(posedge RAW_clk) begin
    #2;
    chk("model_vec", int'(dut_vec), int'(m_vec));
    chk("model_state", int'(arb_state), m_mode);
    chk("no_shoot_through", int'((Forward1 & Backwards1) | (Forward2 & Backwards2)), 0);
  end

  task automatic tick();
    @(posedge RAW_clk);
    #4;
  endtask

  task automatic expect_out(input string nm, input logic [7:0] v, input logic [2:0] s);
    chk({nm, "_vec"}, int'(dut_vec), int'(v));
    chk({nm, "_state"}, int'(arb_state), int'(s));
  endtask

  initial begin
    RAW_reset = 1'b1; ON_CURRENT = 1'b0; InductiveSNSFlag = 1'b0;
    Direction = 1'b0; Rotate = 1'b0; Move = 1'b0; FreqState = 4'd0;
    repeat (3) tick();
    expect_out("reset", 8'd0, 3'd0);
    RAW_reset = 1'b0;
    tick(); expect_out("idle", 8'd0, 3'd0);

    FreqState = 4'd3; Move = 1'b1;
    tick(); expect_out("fwd", FWD, 3'd1);

    Rotate = 1'b1; Direction = 1'b1;
    for (int i = 0; i < DT; i++) begin tick(); expect_out("deadtime", 8'd0, 3'd2); end
    tick(); expect_out("spin_r", SPR, 3'd1);

    ON_CURRENT = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); expect_out("fault_on", 8'd0, 3'd4); end
    ON_CURRENT = 1'b0;
    for (int i = 0; i < FH; i++) begin tick(); expect_out("fault_hold", 8'd0, 3'd4); end
    tick(); expect_out("fault_exit", 8'd0, 3'd0);
    tick(); expect_out("resume", SPR, 3'd1);

    Rotate = 1'b0; FreqState = 4'd0;
    tick(); expect_out("nofreq", 8'd0, 3'd0);
    tick(); expect_out("nofreq2", 8'd0, 3'd0);
    FreqState = 4'd5;
    tick(); expect_out("freq5", FWD, 3'd1);

    ON_CURRENT = 1'b1; InductiveSNSFlag = 1'b1;
    tick(); expect_out("both_flags", 8'd0, 3'd4);
    ON_CURRENT = 1'b0; InductiveSNSFlag = 1'b0;
    for (int i = 0; i < FH; i++) begin tick(); expect_out("both_hold", 8'd0, 3'd4); end
    tick(); expect_out("both_exit", 8'd0, 3'd0);
    tick(); expect_out("refwd", FWD, 3'd1);

    InductiveSNSFlag = 1'b1;
    tick(); expect_out("halt", 8'd0, 3'd3);
    tick(); expect_out("halt2", 8'd0, 3'd3);
    InductiveSNSFlag = 1'b0;
    tick(); expect_out("halt_exit", 8'd0, 3'd0);
    tick(); expect_out("halt_fwd", FWD, 3'd1);

    Rotate = 1'b1; Direction = 1'b0;
    tick(); expect_out("dead_b", 8'd0, 3'd2);
    tick(); expect_out("dead_b2", 8'd0, 3'd2);
    #1 RAW_reset = 1'b1;
    #1 expect_out("async_rst", 8'd0, 3'd0);
    Rotate = 1'b0; Move = 1'b1; FreqState = 4'd1;
    tick();
    RAW_reset = 1'b0;
    tick(); expect_out("post_rst", FWD, 3'd1);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        Move      = 1'($urandom_range(0, 1));
        Rotate    = ($urandom_range(0, 2) == 0);
        Direction = 1'($urandom_range(0, 1));
        FreqState = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      end
      ON_CURRENT = ($urandom_range(0, 59) == 0);
      if (InductiveSNSFlag) begin
        if ($urandom_range(0, 3) == 0) InductiveSNSFlag = 1'b0;
      end else begin
        if ($urandom_range(0, 39) == 0) InductiveSNSFlag = 1'b1;
      end
      RAW_reset = ($urandom_range(0, 499) == 0);
      tick();
    end
    RAW_reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/motor_cmd_arbiter.md
MOTOR_CMD_ARBITER -- requirements
Module: motor_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter DEADTIME_CYC, default 1000, meaning the number of all-off cycles inserted between two different nonzero drive patterns.
REQ-002 The block SHALL have parameter FAULT_HOLD_CYC, default 100000, meaning the number of cycles FAULT is held after ON_CURRENT deasserts.
REQ-003 Both parameters SHALL be in the range 1..2^24-1, and the internal counters SHALL be 24 bits wide.
REQ-004 RAW_clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 RAW_reset  in  1  asynchronous, active-high reset.
REQ-006 ON_CURRENT  in  1  overcurrent flag from motor protection; highest priority.
REQ-007 InductiveSNSFlag  in  1  metal-detected flag; second priority.
REQ-008 Direction  in  1  rotate sense: 1 = spin right, 0 = spin left.
REQ-009 Rotate  in  1  localization rotate request.
REQ-010 Move  in  1  localization forward request.
REQ-011 FreqState  in  4  detected frequency code; 0 means no target.
REQ-012 Forward1, Backwards1, Forward2, Backwards2  out  1 each  H-bridge direction bits (side 1 = left, side 2 = right).
REQ-013 speedL, speedR  out  2 each  PWM speed codes.
REQ-014 arb_state  out  3  current state code: IDLE=0, DRIVE=1, DEADTIME=2, HALT=3, FAULT=4.

Function
REQ-015 The command SHALL be decoded each cycle with strict priority ON_CURRENT > InductiveSNSFlag > Rotate > Move > STOP.
REQ-016 When FreqState==0, Rotate and Move SHALL decode as STOP.
REQ-017 Drive patterns SHALL be encoded as {F1,B1,F2,B2,speedL,speedR}:
- FWD = 1,0,1,0,11,11
- SPIN_R (Rotate, Direction=1) = 1,0,0,1,10,10
- SPIN_L (Rotate, Direction=0) = 0,1,1,0,10,10
- STOP = all 0
REQ-018 All outputs SHALL be registered, and Fx and Bx of the same side SHALL never both be 1 in any cycle.
REQ-019 IDLE: outputs STOP; a nonstop command SHALL enter DRIVE with its pattern visible on the outputs exactly one cycle after the command is sampled.
REQ-020 DRIVE: the pattern SHALL be held while the decoded command is unchanged.
REQ-021 DRIVE: when the decoded command becomes STOP, the block SHALL go to IDLE with outputs 0 the next cycle.
REQ-022 DRIVE: when the decoded command becomes a different nonstop pattern, the block SHALL go to DEADTIME.
REQ-023 DEADTIME: outputs SHALL be 0 for exactly DEADTIME_CYC cycles, and command changes during this window SHALL NOT restart the count.
REQ-024 DEADTIME expiry: the command SHALL be re-sampled at the last cycle; nonstop -> DRIVE with that pattern, STOP -> IDLE.
REQ-025 From any state, ON_CURRENT=1 SHALL force FAULT the next cycle with outputs 0.
REQ-026 FAULT: the hold counter SHALL reload to FAULT_HOLD_CYC every cycle ON_CURRENT=1 and decrement otherwise; on reaching 0 the block SHALL go to IDLE.
REQ-027 From IDLE, DRIVE or DEADTIME, InductiveSNSFlag=1 with ON_CURRENT=0 SHALL force HALT the next cycle with outputs 0.
REQ-028 HALT SHALL be left to IDLE on the first cycle InductiveSNSFlag=0, and ON_CURRENT=1 in HALT SHALL go to FAULT.
REQ-029 Simultaneous ON_CURRENT and InductiveSNSFlag SHALL go to FAULT.
REQ-030 Leaving FAULT or HALT SHALL always pass through IDLE, with no direct return to DRIVE.

Reset
REQ-031 While RAW_reset=1, the block SHALL immediately (asynchronously) drive state IDLE, all direction bits 0, speedL=speedR=00, arb_state=0, and both counters 0.
REQ-032 Reset asserted mid-DEADTIME or mid-FAULT SHALL abandon the operation, and after release the block SHALL start from IDLE.

Verification (bench: DEADTIME_CYC=4, FAULT_HOLD_CYC=8)
REQ-033 FreqState=3, Move=1 from IDLE -> one cycle later F1=F2=1, speedL=speedR=11, arb_state=1.
REQ-034 In DRIVE FWD, set Rotate=1, Direction=1 -> exactly 4 cycles of all-zero outputs with arb_state=2, then F1=1, B2=1, speeds 10.
REQ-035 In DRIVE, ON_CURRENT pulse of 3 cycles -> outputs 0 next cycle, arb_state=4 for 3+8 cycles, then IDLE; the drive resumes one cycle later only if still commanded.
REQ-036 Move=1 with FreqState=0 -> outputs stay 0, arb_state=0; change FreqState to 5 -> FWD one cycle later.
REQ-037 InductiveSNSFlag=1 together with ON_CURRENT=1 -> FAULT; with Inductive only -> HALT, and IDLE one cycle after the flag drops.
REQ-038 RAW_reset asserted mid-DEADTIME, asynchronous to the clock -> outputs 0 before the next edge; after release with Move=1, FreqState=1 -> FWD after 1 cycle with no dead time.
